// File: rtl/mod107_seq_reducer_pkg.sv
// Shared constants, FSM state type and the mod-107 accumulate helper
// for the sequential 100-bit mod-107 reducer.
package mod107_pkg;

  localparam int MOD      = 107;
  localparam int CHUNK    = 6;
  localparam int N_CHUNKS = 17;
  localparam int RES_W    = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Both inputs are already reduced, so one conditional subtract suffices.
  function automatic logic [6:0] modadd107(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 8'd107) begin
      sum = sum - 8'd107;
    end
    return sum[6:0];
  endfunction

endpackage

// File: rtl/mod107_seq_reducer_chunk_lut.sv
// Combinational residue of one 6-bit chunk at position idx:
// r = (v * 2^(6*idx)) mod 107, via a per-index weight table.
module mod107_chunk_lut
  import mod107_pkg::*;
(
  input  logic [4:0] idx,
  input  logic [5:0] v,
  output logic [6:0] r
);

  logic [6:0]  weight;
  logic [12:0] prod;

  // weight = 2^(6*idx) mod 107; unreachable indices contribute nothing.
  always_comb begin
    weight = 7'd0;
    case (idx)
      5'd0:    weight = 7'd1;
      5'd1:    weight = 7'd64;
      5'd2:    weight = 7'd30;
      5'd3:    weight = 7'd101;
      5'd4:    weight = 7'd44;
      5'd5:    weight = 7'd34;
      5'd6:    weight = 7'd36;
      5'd7:    weight = 7'd57;
      5'd8:    weight = 7'd10;
      5'd9:    weight = 7'd105;
      5'd10:   weight = 7'd86;
      5'd11:   weight = 7'd47;
      5'd12:   weight = 7'd12;
      5'd13:   weight = 7'd19;
      5'd14:   weight = 7'd39;
      5'd15:   weight = 7'd35;
      5'd16:   weight = 7'd100;
      default: weight = 7'd0;
    endcase
  end

  always_comb begin
    prod = {7'd0, v} * {6'd0, weight};
    r    = 7'(prod % 13'd107);
  end

endmodule

// File: rtl/mod107_seq_reducer.sv
// Reduces a 100-bit operand modulo 107 one 6-bit chunk per cycle,
// sharing a single chunk-residue lookup, with valid/ready on both sides.
module mod107_seq_reducer
  import mod107_pkg::*;
#(
  parameter int N_BITS   = 100,
  parameter int CHUNK    = 6,
  parameter int MOD      = 107,
  parameter int N_CHUNKS = (N_BITS + CHUNK - 1) / CHUNK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_data,
  output logic              busy
);

  localparam int PAD_W = N_CHUNKS * CHUNK;
  localparam logic [4:0] LAST_IDX = 5'(N_CHUNKS - 1);

  if (MOD != 107) begin : g_mod_check
    $error("mod107_seq_reducer only supports MOD = 107");
  end

  state_t state_q, state_d;

  logic [N_CHUNKS-1:0][CHUNK-1:0] op_q;
  logic [4:0] idx_q;
  logic [6:0] acc_q;
  logic [6:0] out_q;
  logic [6:0] lut_r;
  logic [6:0] acc_next;

  mod107_chunk_lut u_lut (
    .idx (idx_q),
    .v   (op_q[idx_q]),
    .r   (lut_r)
  );

  assign acc_next = modadd107(acc_q, lut_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand is captured only on the accept edge; later in_data changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      idx_q <= 5'd0;
      acc_q <= 7'd0;
      out_q <= 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q  <= {{(PAD_W - N_BITS){1'b0}}, in_data};
            idx_q <= 5'd0;
            acc_q <= 7'd0;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          if (idx_q == LAST_IDX) begin
            out_q <= acc_next;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_mod107_seq_reducer.sv
// Self-checking bench for mod107_seq_reducer: a transaction-level model using
// plain x % 107 plus directed vectors with hand-computed residues.
module tb_mod107_seq_reducer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [99:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [6:0]  out_data;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int          m_phase = 0;
  int          m_cnt = 0;
  logic [99:0] m_x = '0;
  logic [6:0]  m_out = '0;

  mod107_seq_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] golden(input logic [99:0] x);
    logic [99:0] r;
    r = x % 100'd107;
    return r[6:0];
  endfunction

  function automatic logic [99:0] rand100();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[99:0];
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: idle -> 17 counted cycles -> holding result until out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_out   <= '0;
    end else begin
      cyc <= cyc + 1;
      case (m_phase)
        0: if (in_valid) begin
             m_phase <= 1;
             m_cnt   <= 0;
             m_x     <= in_data;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt == 16) begin
               m_phase <= 2;
               m_out   <= golden(m_x);
             end
           end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("cyc_in_ready", longint'(in_ready), longint'(m_phase == 0));
    checkOutput("cyc_out_valid", longint'(out_valid), longint'(m_phase == 2));
    checkOutput("cyc_busy", longint'(busy), longint'(m_phase != 0));
    checkOutput("cyc_out_data", longint'(out_data), longint'(m_out));
    checkOutput("cyc_range", longint'(out_data < 7'd107), 1);
  end

  task automatic applyStimulus(input logic [99:0] x, input int expected, input int hold);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(m_phase == 1 && m_cnt == 0) && n < 50);
    checkOutput("accept", longint'(m_phase == 1), 1);
    in_valid = 1'b0;
    in_data  = rand100();
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
      in_data = rand100();
    end
    checkOutput("latency", n, 17);
    checkOutput("value", longint'(out_data), expected);
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", longint'(out_valid), 1);
      checkOutput("hold_data", longint'(out_data), expected);
      checkOutput("hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_idle", longint'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [99:0] ops [5];
    logic [99:0] ones;
    int prev_cyc;
    int n;

    ones = '1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_in_ready", longint'(in_ready), 1);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_out_data", longint'(out_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(100'd0, 0, 0);
    applyStimulus(100'd1, 1, 0);
    applyStimulus(100'd106, 106, 0);
    applyStimulus(100'd107, 0, 10);
    applyStimulus(100'd4096, 30, 0);
    applyStimulus(ones, 101, 0);

    // Back-to-back with continuous in_valid and out_ready.
    for (int i = 0; i < 5; i++) ops[i] = rand100();
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = ops[0];
    prev_cyc  = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!(m_phase == 1 && m_cnt == 0) && n < 40);
      checkOutput("b2b_accept", longint'(m_phase == 1 && m_cnt == 0), 1);
      if (i > 0) checkOutput("b2b_spacing", cyc - prev_cyc, 19);
      prev_cyc = cyc;
      in_data  = (i < 4) ? ops[i + 1] : rand100();
    end
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset in the middle of a run.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand100();
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(m_phase == 1 && m_cnt == 0) && n < 40);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", longint'(in_ready), 1);
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_busy", longint'(busy), 0);
    checkOutput("midrst_out_data", longint'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(100'd1000, 37, 0);

    // Random regression with random handshakes.
    repeat (8000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rand100();
      out_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
